// File: rtl/cpu_cfg_responder.sv
// Configuration-bus responder for the ATM switch cell lookup table.
// Serves Intel/Motorola CPU accesses with wait states and a pipelined datapath lookup port.
module cpu_cfg_responder #(
    parameter int unsigned NUM_TX      = 4,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 BusMode,
    input  logic [ADDR_W-1:0]    Addr,
    input  logic                 Sel,
    input  logic [NUM_TX+11:0]   DataIn,
    input  logic                 Rd_DS,
    input  logic                 Wr_RW,
    output logic [NUM_TX+11:0]   DataOut,
    output logic                 Rdy_Dtack,
    input  logic                 lk_req,
    input  logic [ADDR_W-1:0]    lk_vpi,
    output logic                 lk_valid,
    output logic [NUM_TX+11:0]   lk_cfg,
    output logic                 init_done
);

    localparam int unsigned CfgW  = NUM_TX + 12;
    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic [1:0] {StInit, StIdle, StWait, StAck} state_e;

    state_e              state_q, state_d;
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0]   init_cnt_q;
    logic                init_done_q;
    logic                mode_q;
    logic                rd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [CfgW-1:0]     data_q;
    logic [CfgW-1:0]     data_out_q;
    logic                lk_valid_q;
    logic [CfgW-1:0]     lk_cfg_q;
    logic [CfgW-1:0]     mem [Depth];

    logic                cur_mode;
    logic                act;
    logic                act_rd;
    logic                acc_rd;
    logic [ADDR_W-1:0]   acc_addr;
    logic [CfgW-1:0]     acc_data;
    logic                latch_en;
    logic                enter_ack;

    // Bus flavour is frozen once an access leaves IDLE.
    assign cur_mode = (state_q == StInit || state_q == StIdle) ? BusMode : mode_q;
    assign act      = !Sel && (cur_mode ? (!Rd_DS ^ !Wr_RW) : !Rd_DS);
    assign act_rd   = cur_mode ? !Rd_DS : Wr_RW;

    // With zero wait states the table is accessed straight from the live bus.
    assign acc_rd   = (state_q == StIdle) ? act_rd : rd_q;
    assign acc_addr = (state_q == StIdle) ? Addr   : addr_q;
    assign acc_data = (state_q == StIdle) ? DataIn : data_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        latch_en   = 1'b0;
        enter_ack  = 1'b0;
        unique case (state_q)
            StInit: begin
                if (&init_cnt_q) state_d = StIdle;
            end
            StIdle: begin
                wait_cnt_d = '0;
                if (act) begin
                    latch_en = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = StAck;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!act) begin
                    state_d = StIdle;
                end else if (wait_cnt_q == 4'(WAIT_CYCLES - 1)) begin
                    state_d   = StAck;
                    enter_ack = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            StAck: begin
                if (!act) state_d = StIdle;
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StInit;
            wait_cnt_q  <= '0;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            mode_q      <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            data_out_q  <= '0;
            lk_valid_q  <= 1'b0;
            lk_cfg_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            lk_valid_q <= lk_req;
            if (lk_req) lk_cfg_q <= mem[lk_vpi];
            if (state_q == StInit) begin
                init_cnt_q <= init_cnt_q + 1'b1;
                if (&init_cnt_q) init_done_q <= 1'b1;
            end
            if (state_q == StIdle) mode_q <= BusMode;
            if (latch_en) begin
                rd_q   <= act_rd;
                addr_q <= Addr;
                data_q <= DataIn;
            end
            if (enter_ack && acc_rd) data_out_q <= mem[acc_addr];
        end
    end

    // Table storage is not reset; INIT clears it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StInit) begin
                mem[init_cnt_q] <= '0;
            end else if (enter_ack && !acc_rd) begin
                mem[acc_addr] <= acc_data;
            end
        end
    end

    assign Rdy_Dtack = cur_mode ? (state_q == StAck) : (state_q != StAck);
    assign DataOut   = data_out_q;
    assign lk_valid  = lk_valid_q;
    assign lk_cfg    = lk_cfg_q;
    assign init_done = init_done_q;

endmodule
